// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing
// with ready-handshaked memory states and a wait timeout. Optional: MULTICYCLE_JUMP_EN.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_eq_o,
  output logic       pc_write_cond_ne_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [2:0] alu_op_o,
  output logic       instr_done_o,
  output logic       illegal_op_o,
  output logic       fault_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
`ifdef MULTICYCLE_JUMP_EN
    S_JUMP      = 4'd12,
`endif
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_LUI   = 3'b001;
  localparam logic [2:0] ALU_ORI   = 3'b010;
  localparam logic [2:0] ALU_ANDI  = 3'b011;

  localparam bit                   TIMEOUT_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
    CNT_WIDTH'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t               state_q, state_next;
  logic [CNT_WIDTH-1:0] wait_cnt_q;
  logic                 in_mem_state;
  logic                 wait_expired;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
  assign wait_expired = TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LAST) && !mem_ready_i;
  assign state_o      = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RST;
    else        state_q <= state_next;
  end

  // Any state change clears the counter, which covers every entry into a memory state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     wait_cnt_q <= '0;
    else if (state_next != state_q) wait_cnt_q <= '0;
    else if (in_mem_state)          wait_cnt_q <= wait_cnt_q + CNT_WIDTH'(1);
  end

  always_comb begin
    state_next         = state_q;
    pc_write_o         = 1'b0;
    pc_write_cond_eq_o = 1'b0;
    pc_write_cond_ne_o = 1'b0;
    i_or_d_o           = 1'b0;
    mem_read_o         = 1'b0;
    mem_write_o        = 1'b0;
    ir_write_o         = 1'b0;
    mem_to_reg_o       = 1'b0;
    reg_dst_o          = 1'b0;
    reg_write_o        = 1'b0;
    alu_src_a_o        = 1'b0;
    alu_src_b_o        = 2'b00;
    pc_source_o        = 2'b00;
    alu_op_o           = 3'b000;
    illegal_op_o       = 1'b0;
    fault_o            = 1'b0;

    case (state_q)
      S_RST: state_next = S_FETCH;
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i)       state_next = S_DECODE;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        alu_op_o    = ALU_ADD;
        case (opcode_i)
          OP_RTYPE:                         state_next = S_R_EXEC;
          OP_ADDI, OP_LUI, OP_ORI, OP_ANDI: state_next = S_I_EXEC;
          OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_next = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:                             state_next = S_JUMP;
`endif
          default: begin
            state_next   = S_FETCH;
            illegal_op_o = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = ALU_ADD;
        state_next  = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        i_or_d_o   = 1'b1;
        mem_read_o = 1'b1;
        if (mem_ready_i)       state_next = S_MEM_WB;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEM_WRITE: begin
        i_or_d_o    = 1'b1;
        mem_write_o = 1'b1;
        if (mem_ready_i)       state_next = S_FETCH;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_R_EXEC, S_R_WB: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_RTYPE;
        if (state_q == S_R_WB) begin
          reg_dst_o   = 1'b1;
          reg_write_o = 1'b1;
          state_next  = S_FETCH;
        end else begin
          state_next  = S_R_WB;
        end
      end
      S_I_EXEC, S_I_WB: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (opcode_i)
          OP_LUI:  alu_op_o = ALU_LUI;
          OP_ORI:  alu_op_o = ALU_ORI;
          OP_ANDI: alu_op_o = ALU_ANDI;
          default: alu_op_o = ALU_ADD;
        endcase
        if (state_q == S_I_WB) begin
          reg_write_o = 1'b1;
          state_next  = S_FETCH;
        end else begin
          state_next  = S_I_WB;
        end
      end
      S_BRANCH: begin
        alu_src_a_o        = 1'b1;
        alu_op_o           = ALU_SUB;
        pc_source_o        = 2'b01;
        pc_write_cond_eq_o = (opcode_i == OP_BEQ);
        pc_write_cond_ne_o = (opcode_i == OP_BNE);
        state_next         = S_FETCH;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b10;
        state_next  = S_FETCH;
      end
`endif
      S_FAULT: fault_o = 1'b1;
      default: state_next = S_RST;
    endcase
  end

  // Completion is the transition back into FETCH; waiting in FETCH and leaving RST are not completions.
  assign instr_done_o = (state_next == S_FETCH) && (state_q != S_FETCH) &&
                        (state_q != S_RST);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (timeout set to 4 cycles).
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o, i_or_d_o;
  logic       mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o;
  logic       reg_write_o, alu_src_a_o, instr_done_o, illegal_op_o, fault_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_WIDTH(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .opcode_i           (opcode_i),
    .mem_ready_i        (mem_ready_i),
    .pc_write_o         (pc_write_o),
    .pc_write_cond_eq_o (pc_write_cond_eq_o),
    .pc_write_cond_ne_o (pc_write_cond_ne_o),
    .i_or_d_o           (i_or_d_o),
    .mem_read_o         (mem_read_o),
    .mem_write_o        (mem_write_o),
    .ir_write_o         (ir_write_o),
    .mem_to_reg_o       (mem_to_reg_o),
    .reg_dst_o          (reg_dst_o),
    .reg_write_o        (reg_write_o),
    .alu_src_a_o        (alu_src_a_o),
    .alu_src_b_o        (alu_src_b_o),
    .pc_source_o        (pc_source_o),
    .alu_op_o           (alu_op_o),
    .instr_done_o       (instr_done_o),
    .illegal_op_o       (illegal_op_o),
    .fault_o            (fault_o),
    .state_o            (state_o)
  );

  always #5 clk = ~clk;

  logic [21:0] all_outs;
  assign all_outs = {pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o, i_or_d_o,
                     mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o,
                     reg_write_o, alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o,
                     instr_done_o, illegal_op_o, fault_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and let outputs settle; inputs may then be changed before settle().
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    opcode_i    = 6'h00;
    mem_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1; settle();
    check("rst_state", state_o, 0);
    check("rst_outs", all_outs, 0);

    // R-type: 0,1,2,7,8,1
    reset = 1'b1;
    tick(); settle();
    check("r_fetch_state", state_o, 1);
    check("r_fetch_ir_write", ir_write_o, 1);
    check("r_fetch_pc_write", pc_write_o, 1);
    check("r_fetch_mem_read", mem_read_o, 1);
    check("r_fetch_src_b", alu_src_b_o, 1);
    check("r_fetch_alu_op", alu_op_o, 3'b100);
    check("r_fetch_done", instr_done_o, 0);
    tick(); settle();
    check("r_decode_state", state_o, 2);
    check("r_decode_src_b", alu_src_b_o, 3);
    tick(); settle();
    check("r_exec_state", state_o, 7);
    check("r_exec_alu_op", alu_op_o, 3'b111);
    check("r_exec_reg_write", reg_write_o, 0);
    tick(); settle();
    check("r_wb_state", state_o, 8);
    check("r_wb_alu_op", alu_op_o, 3'b111);
    check("r_wb_reg_dst", reg_dst_o, 1);
    check("r_wb_reg_write", reg_write_o, 1);
    check("r_wb_done", instr_done_o, 1);
    tick(); opcode_i = 6'h23; settle();
    check("r_back_fetch", state_o, 1);

    // LW with three wait cycles; ready on the 4th cycle hits the timeout boundary and must win
    tick(); settle();
    check("lw_decode", state_o, 2);
    tick(); settle();
    check("lw_mem_addr", state_o, 3);
    check("lw_addr_src_b", alu_src_b_o, 2);
    check("lw_addr_src_a", alu_src_a_o, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); mem_ready_i = (i == 3); settle();
      check("lw_mem_read_state", state_o, 4);
      check("lw_mem_read", mem_read_o, 1);
      check("lw_i_or_d", i_or_d_o, 1);
    end
    tick(); settle();
    check("lw_mem_wb_state", state_o, 5);
    check("lw_mem_to_reg", mem_to_reg_o, 1);
    check("lw_reg_write", reg_write_o, 1);
    check("lw_reg_dst", reg_dst_o, 0);
    check("lw_done", instr_done_o, 1);
    check("lw_no_fault", fault_o, 0);
    tick(); opcode_i = 6'h05; settle();
    check("lw_back_fetch", state_o, 1);

    // BNE
    tick(); settle();
    check("bne_decode", state_o, 2);
    tick(); settle();
    check("bne_state", state_o, 11);
    check("bne_cond_ne", pc_write_cond_ne_o, 1);
    check("bne_cond_eq", pc_write_cond_eq_o, 0);
    check("bne_alu_op", alu_op_o, 3'b101);
    check("bne_pc_source", pc_source_o, 1);
    check("bne_done", instr_done_o, 1);
    tick(); opcode_i = 6'h0D; settle();
    check("bne_back_fetch", state_o, 1);

    // ORI
    tick(); settle();
    tick(); settle();
    check("ori_exec_state", state_o, 9);
    check("ori_alu_op", alu_op_o, 3'b010);
    check("ori_src_b", alu_src_b_o, 2);
    tick(); settle();
    check("ori_wb_state", state_o, 10);
    check("ori_wb_reg_write", reg_write_o, 1);
    check("ori_wb_reg_dst", reg_dst_o, 0);
    check("ori_wb_alu_op", alu_op_o, 3'b010);
    tick(); opcode_i = 6'h3F; settle();

    // Illegal opcode
    tick(); settle();
    check("ill_state", state_o, 2);
    check("ill_pulse", illegal_op_o, 1);
    check("ill_done", instr_done_o, 1);
    check("ill_reg_write", reg_write_o, 0);
    tick(); opcode_i = 6'h02; settle();
    check("ill_back_fetch", state_o, 1);
    check("ill_pulse_gone", illegal_op_o, 0);

    // Jump opcode
    tick(); settle();
    check("j_decode", state_o, 2);
`ifdef MULTICYCLE_JUMP_EN
    check("j_no_illegal", illegal_op_o, 0);
    tick(); settle();
    check("j_state", state_o, 12);
    check("j_pc_write", pc_write_o, 1);
    check("j_pc_source", pc_source_o, 2);
    check("j_done", instr_done_o, 1);
`else
    check("j_illegal", illegal_op_o, 1);
    check("j_done", instr_done_o, 1);
`endif
    tick(); opcode_i = 6'h2B; settle();
    check("j_back_fetch", state_o, 1);

    // SW, then asynchronous reset in the middle of MEM_WRITE
    tick(); settle();
    tick(); mem_ready_i = 1'b0; settle();
    check("sw_mem_addr", state_o, 3);
    tick(); settle();
    check("sw_state", state_o, 6);
    check("sw_mem_write", mem_write_o, 1);
    check("sw_i_or_d", i_or_d_o, 1);
    #1 reset = 1'b0;
    #1;
    check("sw_rst_mem_write", mem_write_o, 0);
    check("sw_rst_state", state_o, 0);

    // Timeout: memory never ready in FETCH
    tick(); reset = 1'b1; settle();
    check("to_still_rst", state_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      check("to_fetch_state", state_o, 1);
      check("to_fetch_ir_write", ir_write_o, 0);
    end
    tick(); settle();
    check("to_fault_state", state_o, 15);
    check("to_fault", fault_o, 1);
    check("to_fault_mem_read", mem_read_o, 0);
    mem_ready_i = 1'b1;
    repeat (3) tick();
    settle();
    check("to_fault_held", fault_o, 1);
    check("to_fault_state_held", state_o, 15);
    reset = 1'b0;
    #1;
    check("to_rst_state", state_o, 0);
    check("to_rst_outs", all_outs, 0);
    tick(); reset = 1'b1; settle();
    tick(); settle();
    check("to_refetch", state_o, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore/Mealy FSM control unit for the multi-cycle MIPS datapath. It supersedes the single-cycle combinational opcode decoder: every instruction runs through a fixed sequence of fetch, decode, execute, memory and write-back states. All memory accesses wait on a ready handshake, guarded by a parametrised timeout. It drives the shared memory port, IR/PC write enables, ALU operand muxes and register-file controls.

## Interface
- MEM_TIMEOUT, 16: max cycles a memory state waits for `mem_ready_i`; 0 disables the timeout.
- CNT_WIDTH, 5: wait-counter width; must satisfy 2^CNT_WIDTH > MEM_TIMEOUT.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode_i  input  6  opcode from the instruction register; stable from DECODE to end of instruction.
- mem_ready_i  input  1  memory completes the current access this cycle.
- pc_write_o  output  1  unconditional PC load.
- pc_write_cond_eq_o  output  1  PC load if ALU zero.
- pc_write_cond_ne_o  output  1  PC load if ALU not zero.
- i_or_d_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  output  1  memory read request.
- mem_write_o  output  1  memory write request.
- ir_write_o  output  1  instruction register load.
- mem_to_reg_o  output  1  write-back data select: 1 = MDR.
- reg_dst_o  output  1  destination select: 1 = rd, 0 = rt.
- reg_write_o  output  1  register-file write.
- alu_src_a_o  output  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b_o  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- pc_source_o  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_op_o  output  3  ALU operation: 100 ADD, 101 SUB, 111 R-type (funct), 001 LUI, 010 ORI, 011 ANDI.
- instr_done_o  output  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op_o  output  1  one-cycle pulse in DECODE for an unsupported opcode.
- fault_o  output  1  level: memory timeout, held until reset.
- state_o  output  4  current state, for debug.

## Operation
- State encoding:
  - RST = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5, MEM_WRITE = 6
  - R_EXEC = 7, R_WB = 8, I_EXEC = 9, I_WB = 10, BRANCH = 11, JUMP = 12, FAULT = 15.
- Any output not listed for a state is 0 in that state.
- RST: all outputs 0. Goes to FETCH on the first edge after reset deasserts.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=100, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready_i` (Mealy).
  - Stays in FETCH until `mem_ready_i`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=100 (branch target to ALUOut). Next state by opcode:
  - 0x00 → R_EXEC
  - 0x08, 0x0F, 0x0D, 0x0C → I_EXEC
  - 0x23, 0x2B → MEM_ADDR
  - 0x04, 0x05 → BRANCH
  - 0x02 → JUMP (only with `JUMP_EN`)
  - anything else → FETCH, with `illegal_op_o`=1 and `instr_done_o`=1.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=100. Next: MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: `i_or_d`=1, `mem_read`=1. On `mem_ready_i` goes to MEM_WB.
- MEM_WB: `mem_to_reg`=1, `reg_dst`=0, `reg_write`=1. Goes to FETCH.
- MEM_WRITE: `i_or_d`=1, `mem_write`=1. On `mem_ready_i` goes to FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=111. Goes to R_WB, which holds the same ALU controls plus `reg_dst`=1, `reg_write`=1, then goes to FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op` by opcode: ADDI 100, LUI 001, ORI 010, ANDI 011. Goes to I_WB, which holds the same ALU controls plus `reg_dst`=0, `reg_write`=1, then goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=101, `pc_source`=01.
  - `pc_write_cond_eq`=1 for 0x04, `pc_write_cond_ne`=1 for 0x05.
  - Goes to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Goes to FETCH.
- `instr_done_o`=1 in every cycle whose next state is FETCH, except RST→FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle the FSM stays in one of those states with `mem_ready_i`=0.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT−1 with `mem_ready_i`=0, next state is FAULT.
- FAULT: `fault_o`=1, all other outputs 0. Only reset exits FAULT.

## Timing
- Reset value: state=RST, counter=0, every output 0. Reset is asynchronous, so strobes drop in the same cycle it asserts, mid-access included.
- Latency with zero-wait memory (cycles from entering FETCH to the `instr_done_o` cycle, inclusive):
  - R-type, I-type, SW: 4
  - LW: 5
  - BEQ, BNE, J: 3
  - illegal opcode: 2
- Each wait cycle adds one cycle.
- `mem_ready_i` arriving on the cycle the counter reaches MEM_TIMEOUT−1 wins: no fault.
- `mem_ready_i` asserted outside memory states is ignored.

## Configuration
- `MULTICYCLE_JUMP_EN` defined: opcode 0x02 goes to JUMP, and `pc_source_o` can be 10.
- Not defined: 0x02 is illegal, the JUMP state is absent, and `pc_source_o` never drives 10.

## Test plan
- Reset release, `mem_ready_i`=1, opcode 0x00 → `state_o` sequence 0,1,2,7,8,1; in R_WB `alu_op`=111, `reg_dst`=1, `reg_write`=1, `instr_done`=1.
- LW (0x23), `mem_ready_i` low for 3 cycles in MEM_READ → MEM_READ lasts 4 cycles with `mem_read`=1, `i_or_d`=1; MEM_WB then has `mem_to_reg`=1, `reg_write`=1.
- BNE (0x05) → BRANCH has `pc_write_cond_ne`=1, `pc_write_cond_eq`=0, `alu_op`=101, `pc_source`=01; back in FETCH 3 cycles after entering it.
- MEM_TIMEOUT=4, `mem_ready_i`=0 in FETCH → FAULT entered after 4 FETCH cycles, `fault_o`=1 and persists; reset pulse returns to RST, then FETCH.
- Opcode 0x3F → `illegal_op_o` and `instr_done_o` pulse in DECODE, next state FETCH, `reg_write` never asserted.
- Opcode 0x02 → with `MULTICYCLE_JUMP_EN`: JUMP has `pc_write`=1, `pc_source`=10. Without it: `illegal_op_o` pulse. Separately, reset asserted mid-MEM_WRITE drops `mem_write_o` to 0 immediately.
